register_file: RTL and testbench

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file_if.sv | 37 +++
 rtl/register_file.sv | 90 +++++++++
 tb/tb_register_file.sv | 139 +++++++++++++
 3 files changed

// File: rtl/register_file_if.sv
// Core-side bus of the register file: two read ports, one write port and clear status.
// The core drives the master side; the register file implements the slave side.
interface register_file_if;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        reg_write;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic        init_busy;
    logic [4:0]  clear_index;

    modport master (
        output read_reg1,
        output read_reg2,
        output write_reg,
        output write_data,
        output reg_write,
        input  read_data1,
        input  read_data2,
        input  init_busy,
        input  clear_index
    );

    modport slave (
        input  read_reg1,
        input  read_reg2,
        input  write_reg,
        input  write_data,
        input  reg_write,
        output read_data1,
        output read_data2,
        output init_busy,
        output clear_index
    );
endinterface

// File: rtl/register_file.sv
// 32 x 32-bit register file, zeroed by a 32-cycle clear walk after reset instead of a
// per-register reset. Reads are combinational with write-first bypass; x0 reads zero.
module register_file (
    input  logic            clk,
    input  logic            reset,
    register_file_if.slave  io_rf
);
    typedef enum logic {StClear, StReady} state_e;

    state_e      r_state;
    state_e      w_state_next;
    logic [4:0]  r_clear_index;
    logic [4:0]  w_clear_index_next;
    logic [31:0] r_mem [32];

    logic        w_mem_we;
    logic [4:0]  w_mem_addr;
    logic [31:0] w_mem_wdata;
    logic        w_user_we;
    logic [31:0] w_rd1;
    logic [31:0] w_rd2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= StClear;
            r_clear_index <= 5'd0;
        end else begin
            r_state       <= w_state_next;
            r_clear_index <= w_clear_index_next;
        end
    end

    assign w_user_we = io_rf.reg_write && (io_rf.write_reg != 5'd0);

    // Single write port shared by the clear walk and the user; reset blocks both.
    always_comb begin
        w_state_next       = r_state;
        w_clear_index_next = r_clear_index;
        w_mem_we           = 1'b0;
        w_mem_addr         = io_rf.write_reg;
        w_mem_wdata        = io_rf.write_data;
        unique case (r_state)
            StClear: begin
                w_mem_we           = !reset;
                w_mem_addr         = r_clear_index;
                w_mem_wdata        = 32'h0;
                w_clear_index_next = r_clear_index + 5'd1;
                if (r_clear_index == 5'd31) begin
                    w_state_next = StReady;
                end
            end
            StReady: begin
                w_mem_we = !reset && w_user_we;
            end
            default: begin
                w_state_next = StClear;
            end
        endcase
    end

    // No reset on the array so it can map onto RAM primitives.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    always_comb begin
        w_rd1 = r_mem[io_rf.read_reg1];
        if (r_state == StClear || io_rf.read_reg1 == 5'd0) begin
            w_rd1 = 32'h0;
        end else if (w_user_we && io_rf.write_reg == io_rf.read_reg1) begin
            w_rd1 = io_rf.write_data;
        end
    end

    always_comb begin
        w_rd2 = r_mem[io_rf.read_reg2];
        if (r_state == StClear || io_rf.read_reg2 == 5'd0) begin
            w_rd2 = 32'h0;
        end else if (w_user_we && io_rf.write_reg == io_rf.read_reg2) begin
            w_rd2 = io_rf.write_data;
        end
    end

    assign io_rf.read_data1  = w_rd1;
    assign io_rf.read_data2  = w_rd2;
    assign io_rf.init_busy   = (r_state == StClear);
    assign io_rf.clear_index = r_clear_index;
endmodule

// File: tb/tb_register_file.sv
// Randomized bench for register_file against a cycle-count based reference model.
module tb_register_file;
    logic clk;
    logic reset;
    int   n_asserts;
    int   n_fail;
    int   busy_seen;

    // Reference model: clear progress as an edge count, contents as a plain array.
    int          m_clear_edges;
    logic [31:0] m_mem [32];

    register_file_if rf ();

    register_file dut (
        .clk   (clk),
        .reset (reset),
        .io_rf (rf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] idx, input logic [4:0] wr,
                                               input logic [31:0] wd, input logic we);
        if (m_clear_edges < 32) return 32'h0;
        if (idx == 5'd0) return 32'h0;
        if (we && wr != 5'd0 && wr == idx) return wd;
        return m_mem[idx];
    endfunction

    function automatic void model_edge(input logic rst, input logic [4:0] wr,
                                       input logic [31:0] wd, input logic we);
        if (rst) begin
            m_clear_edges = 0;
        end else if (m_clear_edges < 32) begin
            m_clear_edges++;
            if (m_clear_edges == 32) begin
                for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
            end
        end else if (we && wr != 5'd0) begin
            m_mem[wr] = wd;
        end
    endfunction

    task automatic cycle(input logic rst, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] wr, input logic [31:0] wd, input logic we);
        logic        exp_busy;
        logic [31:0] exp_idx;
        reset         = rst;
        rf.read_reg1  = r1;
        rf.read_reg2  = r2;
        rf.write_reg  = wr;
        rf.write_data = wd;
        rf.reg_write  = we;
        #4;
        exp_busy = (m_clear_edges < 32);
        exp_idx  = exp_busy ? 32'(m_clear_edges) : 32'h0;
        check_eq("init_busy", {31'h0, rf.init_busy}, {31'h0, exp_busy});
        check_eq("clear_index", {27'h0, rf.clear_index}, exp_idx);
        check_eq("read_data1", rf.read_data1, model_read(r1, wr, wd, we));
        check_eq("read_data2", rf.read_data2, model_read(r2, wr, wd, we));
        if (rf.init_busy) busy_seen++;
        @(posedge clk);
        model_edge(rst, wr, wd, we);
        #1;
    endtask

    task automatic rand_cycle(input logic allow_reset);
        logic rst;
        rst = allow_reset && ($urandom_range(0, 149) == 0);
        cycle(rst, 5'($urandom), 5'($urandom), 5'($urandom), $urandom, 1'($urandom));
    endtask

    initial begin
        n_asserts     = 0;
        n_fail        = 0;
        busy_seen     = 0;
        m_clear_edges = 0;
        for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
        reset         = 1'b1;
        rf.read_reg1  = 5'd0;
        rf.read_reg2  = 5'd0;
        rf.write_reg  = 5'd0;
        rf.write_data = 32'h0;
        rf.reg_write  = 1'b0;
        @(posedge clk);
        #1;
        // Second reset cycle observes the post-reset state.
        cycle(1'b1, 5'd5, 5'd9, 5'd0, 32'h0, 1'b0);

        // Clear walk with a user write to x5 that must be dropped.
        busy_seen = 0;
        for (int i = 0; i < 32; i++) begin
            cycle(1'b0, 5'($urandom), 5'($urandom), 5'd5, 32'hDEADBEEF, 1'b1);
        end
        check_eq("busy_len", 32'(busy_seen), 32'd32);
        cycle(1'b0, 5'd5, 5'd5, 5'd0, 32'h0, 1'b0);
        check_eq("x5_after_clear", rf.read_data1, 32'h0);

        cycle(1'b0, 5'd0, 5'd0, 5'd7, 32'h12345678, 1'b1);
        cycle(1'b0, 5'd7, 5'd7, 5'd0, 32'h0, 1'b0);
        cycle(1'b0, 5'd0, 5'd3, 5'd3, 32'hA5A5A5A5, 1'b1);
        cycle(1'b0, 5'd3, 5'd3, 5'd3, 32'h5A5A5A5A, 1'b1);
        cycle(1'b0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b1);
        cycle(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0);

        for (int i = 0; i < 400; i++) rand_cycle(1'b1);
        for (int i = 0; i < 40; i++) rand_cycle(1'b0);

        for (int i = 1; i < 32; i++) begin
            cycle(1'b0, 5'(i - 1), 5'(i), 5'(i), $urandom | 32'h1, 1'b1);
        end
        for (int i = 0; i < 32; i++) cycle(1'b0, 5'(i), 5'(31 - i), 5'd0, 32'h0, 1'b0);

        // Restart the clear walk part-way through.
        cycle(1'b1, 5'd1, 5'd2, 5'd0, 32'h0, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 5'd1, 5'd2, 5'd4, 32'h4444, 1'b1);
        check_eq("index_before_restart", {27'h0, rf.clear_index}, 32'd10);
        cycle(1'b1, 5'd1, 5'd2, 5'd4, 32'h4444, 1'b1);
        busy_seen = 0;
        for (int i = 0; i < 32; i++) cycle(1'b0, 5'($urandom), 5'($urandom), 5'd9, 32'h9, 1'b1);
        check_eq("busy_len_restart", 32'(busy_seen), 32'd32);
        for (int i = 0; i < 32; i++) cycle(1'b0, 5'(i), 5'(31 - i), 5'd0, 32'h0, 1'b0);

        for (int i = 0; i < 200; i++) rand_cycle(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
